cle_param: RTL and testbench

Parametrised component-labeling engine, successor to the fixed 32×32 CLE. It reads a packed binary image from ROM and writes a label map to SRAM, with one label byte per pixel: 0 for background and a distinct nonzero label per connected object. New relative to the fixed engine: configurable image size and label width, runtime 4/8-connectivity, and label-overflow reporting. It sits between the image ROM and the result SRAM, in place of CLE.

---
 rtl/cle_pkg.sv | 11 +
 rtl/cle_eq_table.sv | 33 +++
 rtl/cle_param.sv | 140 ++++++++++++++
 tb/tb_cle_param.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cle_pkg.sv
// cle_pkg: shared state encoding, width helpers and pixel bit order for cle_param
package cle_pkg;
  typedef enum logic [2:0] {IDLE, P1_FETCH, P1_PIX, P1_MERGE, FLATTEN, P2_RD, P2_WR, DONE} state_t;
  localparam int PIX_MSB = 7;
  function automatic int sa_w(input int w, input int h);
    return $clog2(w * h);
  endfunction
  function automatic int ra_w(input int w, input int h);
    return $clog2(w * h / 8);
  endfunction
endpackage

// File: rtl/cle_eq_table.sv
// cle_eq_table: label equivalence table with one combinational read port and one write port
module cle_eq_table
  import cle_pkg::*;
#(
  parameter int LBL_W = 8,
  parameter int MAX_LBL = 63
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic [LBL_W-1:0] rd_a,
  output logic [LBL_W-1:0] rd_q,
  output logic [LBL_W-1:0] rd_qq,
  input  logic             wr_en,
  input  logic [LBL_W-1:0] wr_a,
  input  logic [LBL_W-1:0] wr_d
);
  localparam int IW = $clog2(MAX_LBL + 1);
  localparam logic [LBL_W-1:0] MAXL = LBL_W'(MAX_LBL);
  logic [LBL_W-1:0] par [2**IW];
  // rd_qq follows one more link; parent[i] <= i keeps it in range
  always_comb begin
    rd_q = (rd_a <= MAXL) ? par[rd_a[IW-1:0]] : '0;
    rd_qq = par[rd_q[IW-1:0]];
  end
  always_ff @(posedge clk) begin
    if (reset || init) begin
      for (int i = 0; i < 2**IW; i++) par[i] <= LBL_W'(i);
    end else if (wr_en && wr_a != '0 && wr_a <= MAXL) begin
      par[wr_a[IW-1:0]] <= wr_d;
    end
  end
endmodule

// File: rtl/cle_param.sv
// cle_param: two-pass connected-component labeller, packed ROM image in, label map to SRAM
module cle_param
  import cle_pkg::*;
#(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int LBL_W = 8,
  parameter int MAX_LBL = 63,
  localparam int RA_W = ra_w(IMG_W, IMG_H),
  localparam int SA_W = sa_w(IMG_W, IMG_H)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             conn8,
  input  logic [7:0]       rom_q,
  output logic [RA_W-1:0]  rom_a,
  input  logic [LBL_W-1:0] sram_q,
  output logic [SA_W-1:0]  sram_a,
  output logic [LBL_W-1:0] sram_d,
  output logic             sram_wen,
  output logic             finish,
  output logic             overflow
);
  localparam int CW = $clog2(IMG_W);
  localparam logic [LBL_W:0] MAXL = (LBL_W+1)'(MAX_LBL);
  state_t state, nxt, adv;
  logic c8, fs, ph, ovf, fg, new_l, root, mw, wr_en;
  logic [SA_W-1:0] pix, pn;
  logic [7:0] sh;
  logic [LBL_W:0] next_lbl, fi;
  logic [LBL_W-1:0] lb [IMG_W];
  logic [LBL_W-1:0] left_r, ul_r, q0, q1, mlbl, ra, rb, cur;
  logic [LBL_W-1:0] lft, up, ul, ur, a, m, w, c1, c2, c3, kq0, kq1;
  logic [LBL_W-1:0] rd_a, rd_q, rd_qq, wr_a, wr_d;
  logic [1:0] qn, kn;
  logic [CW-1:0] col;
  logic row0;
  function automatic logic [LBL_W-1:0] mn(input logic [LBL_W-1:0] x, input logic [LBL_W-1:0] y);
    return x == '0 ? y : y == '0 ? x : x < y ? x : y;
  endfunction
  // left and up-left are vertically adjacent, so they are already one class
  always_comb begin
    col = pix[CW-1:0];
    row0 = pix[SA_W-1:CW] == '0;
    fg = sh[PIX_MSB];
    lft = col != '0 ? left_r : '0;
    up = !row0 ? lb[col] : '0;
    ul = c8 && !row0 && col != '0 ? ul_r : '0;
    ur = c8 && !row0 && col != CW'(IMG_W - 1) ? lb[col + CW'(1)] : '0;
    a = mn(lft, ul);
    m = mn(mn(a, up), ur);
    new_l = fg && m == '0;
    w = !fg ? '0 : m != '0 ? m : next_lbl > MAXL ? MAXL[LBL_W-1:0] : next_lbl[LBL_W-1:0];
    c1 = (a != '0 && a != m) ? a : '0;
    c2 = (up != '0 && up != m && up != c1) ? up : '0;
    c3 = (ur != '0 && ur != m && ur != c1 && ur != c2) ? ur : '0;
    kq0 = c1 != '0 ? c1 : c2 != '0 ? c2 : c3;
    kq1 = c1 != '0 ? (c2 != '0 ? c2 : c3) : (c2 != '0 ? c3 : '0);
    kn = fg ? {1'b0, kq0 != '0} + {1'b0, kq1 != '0} : 2'd0;
    pn = state == P1_PIX ? pix + SA_W'(1) : pix;
    adv = pn == '0 ? FLATTEN : pn[2:0] == 3'd0 ? P1_FETCH : P1_PIX;
    cur = ph ? rb : ra;
    rd_a = state == P1_MERGE ? cur : state == FLATTEN ? fi[LBL_W-1:0] : sram_q;
    root = rd_q == cur;
    mw = state == P1_MERGE && ph && root;
    wr_en = (mw && ra != rb) || (state == FLATTEN && fi < next_lbl);
    wr_a = state == FLATTEN ? fi[LBL_W-1:0] : (ra > rb ? ra : rb);
    wr_d = state == FLATTEN ? rd_qq : (ra > rb ? rb : ra);
  end
  cle_eq_table #(.LBL_W(LBL_W), .MAX_LBL(MAX_LBL)) u_eq (
    .clk(clk), .reset(reset), .init(state == IDLE),
    .rd_a(rd_a), .rd_q(rd_q), .rd_qq(rd_qq),
    .wr_en(wr_en), .wr_a(wr_a), .wr_d(wr_d)
  );
  always_ff @(posedge clk) state <= reset ? IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = P1_FETCH;
      P1_FETCH: nxt = fs ? P1_PIX : P1_FETCH;
      P1_PIX:   nxt = kn != 2'd0 ? P1_MERGE : adv;
      P1_MERGE: nxt = (mw && qn == 2'd1) ? adv : P1_MERGE;
      FLATTEN:  nxt = fi < next_lbl ? FLATTEN : P2_RD;
      P2_RD:    nxt = P2_WR;
      P2_WR:    nxt = &pix ? DONE : P2_RD;
      default:  nxt = DONE;
    endcase
  end
  always_comb begin
    rom_a = pix[SA_W-1:3];
    sram_a = pix;
    sram_wen = !(state == P1_PIX || (state == P2_WR && sram_q != '0));
    sram_d = state == P1_PIX ? w : state == P2_WR ? rd_q : '0;
    finish = state == DONE;
    overflow = ovf;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      {c8, fs, ph, ovf, pix, sh, next_lbl, fi, qn} <= '0;
      {left_r, ul_r, q0, q1, mlbl, ra, rb} <= '0;
      for (int i = 0; i < IMG_W; i++) lb[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          c8 <= conn8;
          next_lbl <= (LBL_W+1)'(1);
          fi <= (LBL_W+1)'(1);
          pix <= '0;
        end
        P1_FETCH: begin
          fs <= !fs;
          if (fs) sh <= rom_q;
        end
        P1_PIX: begin
          pix <= pn;
          sh <= {sh[6:0], 1'b0};
          lb[col] <= w;
          ul_r <= lb[col];
          left_r <= w;
          if (new_l && next_lbl <= MAXL) next_lbl <= next_lbl + (LBL_W+1)'(1);
          if (new_l && next_lbl > MAXL) ovf <= 1'b1;
          {q0, q1, qn, mlbl, ra, rb, ph} <= {kq0, kq1, kn, w, w, kq0, 1'b0};
        end
        P1_MERGE: begin
          if (!root) begin
            if (ph) rb <= rd_q;
            else ra <= rd_q;
          end else if (!ph) begin
            ph <= 1'b1;
          end else begin
            {qn, q0, ra, rb, ph} <= {qn - 2'd1, q1, mlbl, q1, 1'b0};
          end
        end
        FLATTEN: if (fi < next_lbl) fi <= fi + (LBL_W+1)'(1);
        P2_WR: pix <= pix + SA_W'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cle_param.sv
// tb_cle_param: directed scenarios for cle_param at 32x32 with ROM/SRAM models
module tb_cle_param;
  localparam int W = 32;
  localparam int N = 1024;
  logic clk = 0, reset = 1, conn8 = 0;
  logic [7:0] rom_q, sram_q, sram_d;
  logic [6:0] rom_a;
  logic [9:0] sram_a;
  logic sram_wen, finish, overflow;
  logic [7:0] rom [N/8];
  logic [7:0] sram [N];
  int obj [N];
  int wr_cnt = 0;
  int cmp_n = 0, err_n = 0;

  always #5 clk = ~clk;

  cle_param dut (
    .clk(clk), .reset(reset), .conn8(conn8),
    .rom_q(rom_q), .rom_a(rom_a),
    .sram_q(sram_q), .sram_a(sram_a), .sram_d(sram_d), .sram_wen(sram_wen),
    .finish(finish), .overflow(overflow)
  );

  always @(posedge clk) begin
    rom_q <= rom[rom_a];
    sram_q <= sram[sram_a];
    if (!sram_wen) sram[sram_a] <= sram_d;
  end
  always @(posedge clk) wr_cnt <= reset ? 0 : wr_cnt + (sram_wen ? 0 : 1);

  task automatic clear_img();
    for (int i = 0; i < N; i++) obj[i] = 0;
  endtask

  task automatic put(input int r0, input int r1, input int c0, input int c1, input int id);
    for (int r = r0; r <= r1; r++)
      for (int c = c0; c <= c1; c++) obj[r*W + c] = id;
  endtask

  task automatic load_rom();
    for (int k = 0; k < N/8; k++)
      for (int j = 0; j < 8; j++) rom[k][7-j] = obj[8*k + j] != 0;
  endtask

  task automatic checker_img();
    clear_img();
    for (int i = 0; i < N; i++) obj[i] = ((i / W + i % W) % 2 == 0) ? 1 : 0;
  endtask

  task automatic start(input logic c8);
    @(negedge clk);
    reset = 1;
    conn8 = c8;
    for (int i = 0; i < N; i++) sram[i] <= 8'hAA;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (finish !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    cmp_n++;
    if (finish !== 1'b1) begin
      err_n++;
      $display("FAIL %s finish: got %b want 1 (timeout)", nm, finish);
    end
  endtask

  task automatic check_exact(input string nm);
    int bad = 0, first = -1;
    for (int i = 0; i < N; i++)
      if (sram[i] !== 8'(obj[i])) begin
        bad++;
        if (first < 0) first = i;
      end
    cmp_n++;
    if (bad != 0) begin
      err_n++;
      $display("FAIL %s labels: %0d bad pixels, first at %0d got %0d want %0d", nm, bad, first, sram[first], obj[first]);
    end
  endtask

  task automatic check_perm(input string nm);
    int lab [6];
    int bad = 0;
    for (int o = 0; o < 6; o++) lab[o] = -1;
    for (int i = 0; i < N; i++) begin
      if (obj[i] == 0) begin
        if (sram[i] !== 8'd0) bad++;
      end else if (sram[i] === 8'd0) bad++;
      else if (lab[obj[i]] < 0) lab[obj[i]] = int'(sram[i]);
      else if (lab[obj[i]] != int'(sram[i])) bad++;
    end
    for (int x = 1; x < 6; x++)
      for (int y = x + 1; y < 6; y++) if (lab[x] == lab[y]) bad++;
    cmp_n++;
    if (bad != 0) begin
      err_n++;
      $display("FAIL %s permutation: got %0d inconsistencies want 0", nm, bad);
    end
  endtask

  task automatic check_bit(input string nm, input logic got, input logic want);
    cmp_n++;
    if (got !== want) begin
      err_n++;
      $display("FAIL %s: got %b want %b", nm, got, want);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int want);
    cmp_n++;
    if (got != want) begin
      err_n++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic test_reset();
    clear_img();
    load_rom();
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    cmp_n++;
    if ({rom_a, sram_a, sram_d, sram_wen, finish, overflow} !== {7'd0, 10'd0, 8'd0, 1'b1, 1'b0, 1'b0}) begin
      err_n++;
      $display("FAIL reset outputs: got rom_a=%0d sram_a=%0d sram_d=%0d wen=%b fin=%b ovf=%b want 0 0 0 1 0 0",
               rom_a, sram_a, sram_d, sram_wen, finish, overflow);
    end
  endtask

  task automatic test_zero();
    clear_img();
    load_rom();
    start(0);
    wait_done("zero");
    check_exact("zero");
    check_bit("zero overflow", overflow, 1'b0);
    check_int("zero write count", wr_cnt, 1024);
    repeat (5) @(negedge clk);
    check_bit("done finish held", finish, 1'b1);
    check_bit("done wen idle", sram_wen, 1'b1);
  endtask

  task automatic test_ones();
    clear_img();
    put(0, 31, 0, 31, 1);
    load_rom();
    start(0);
    wait_done("ones");
    check_exact("ones");
    check_bit("ones overflow", overflow, 1'b0);
    check_int("ones write count", wr_cnt, 2048);
  endtask

  task automatic test_diag();
    clear_img();
    obj[0] = 1;
    obj[33] = 2;
    load_rom();
    start(0);
    wait_done("diag4");
    check_exact("diag4");
    obj[33] = 1;
    start(1);
    wait_done("diag8");
    check_exact("diag8");
  endtask

  task automatic test_u_shape();
    clear_img();
    put(0, 15, 2, 2, 1);
    put(0, 15, 10, 10, 1);
    put(15, 15, 2, 10, 1);
    load_rom();
    start(0);
    wait_done("u_shape");
    check_exact("u_shape");
  endtask

  task automatic test_overflow();
    checker_img();
    load_rom();
    start(0);
    wait_done("checker");
    check_bit("checker overflow", overflow, 1'b1);
  endtask

  task automatic test_reset_mid();
    checker_img();
    load_rom();
    start(0);
    repeat (500) @(negedge clk);
    check_bit("mid overflow before reset", overflow, 1'b1);
    reset = 1;
    clear_img();
    put(2, 5, 2, 6, 1);
    put(8, 13, 12, 12, 2);
    put(8, 13, 18, 18, 2);
    put(13, 13, 12, 18, 2);
    put(20, 22, 25, 30, 3);
    put(28, 28, 3, 3, 4);
    put(0, 4, 20, 20, 5);
    put(0, 4, 24, 24, 5);
    put(0, 4, 28, 28, 5);
    put(4, 4, 20, 28, 5);
    load_rom();
    for (int i = 0; i < N; i++) sram[i] <= 8'hAA;
    conn8 = 1;
    @(negedge clk);
    check_bit("mid overflow cleared", overflow, 1'b0);
    check_bit("mid finish cleared", finish, 1'b0);
    @(negedge clk);
    reset = 0;
    wait_done("five_obj");
    check_perm("five_obj");
    check_bit("five_obj overflow", overflow, 1'b0);
  endtask

  initial begin
    test_reset();
    test_zero();
    test_ones();
    test_diag();
    test_u_shape();
    test_overflow();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule
